muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
Iterative RV32M multiply/divide unit with its controlling FSM. It sits beside the ALU in the execute stage. The decoder raises start for OP/funct7=0000001. The FSM sequences a shift-add multiplier or a restoring divider over WIDTH cycles. It holds busy to stall the pipeline and pulses done with the result. Latency is fixed for every operation, so stall logic and the bench have no data-dependent timing.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.
CNT_W, $clog2(WIDTH), width of iteration counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears FSM and all outputs
start  input  1  request; sampled only in IDLE
kill  input  1  synchronous abort (pipeline flush); returns to IDLE
Funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  input  WIDTH  rs1 (multiplicand / dividend)
SrcB  input  WIDTH  rs2 (multiplier / divisor)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; Result valid in that cycle
Result  output  WIDTH  registered result; holds until next completion

Behaviour:
- Reset values: state IDLE, busy 0, done 0, Result 0, counter 0. Reset has priority over kill and start.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at an edge: capture Funct3, SrcA, SrcB and the sign flags. Signed operands are MUL/MULH/DIV/REM both, MULHSU rs1 only. Convert signed negative operands to magnitude. Clear the accumulator and set counter=0. Go to CALC.
- CALC, one iteration per edge:
  - Multiply: 2*WIDTH-bit shift-add on magnitudes.
  - Divide: restoring step. Remainder shifts left one bit, subtract the divisor magnitude, restore if the result is negative, shift the quotient bit in.
  - counter increments each edge. After the edge where counter==WIDTH-1, go to FIX.
- FIX, one edge:
  - Multiply sign: negate the product if the operand signs differ.
  - Divide signs: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Apply the special cases below.
  - Select the output: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
  - Write Result and go to DONE.
- DONE: done=1 for exactly this cycle, busy=1. Next edge goes to IDLE.
- Timing: start sampled at the end of cycle 0 gives busy=1 in cycles 1..WIDTH+2 and done=1 in cycle WIDTH+2 (cycle 34 for WIDTH=32). A new start is accepted in cycle WIDTH+3 at the earliest.
- start while busy (including DONE) is ignored, not queued.
- Divide by zero, from the original SrcB, resolved in FIX:
  - DIV/DIVU give all ones.
  - REM/REMU give the dividend unchanged.
  - Latency is unchanged.
- Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF):
  - DIV gives 0x80000000 and REM gives 0.
  - Magnitude arithmetic must not corrupt the result; the 0x80000000 magnitude is held in WIDTH bits unsigned.
- kill=1 at any edge in CALC/FIX/DONE goes to IDLE next cycle. Result is not written (it keeps its previous value) and done stays 0. kill in IDLE has no effect, even with start=1: kill wins.
- Reset mid-operation behaves as kill and also clears Result to 0.
- Operand inputs may change after the capture edge without affecting the operation.

Test Plan:
- Reset mid-CALC, then MUL SrcA=7, SrcB=0xFFFFFFFD started the cycle after reset deasserts -> no done before; busy rises next cycle; done in cycle 34 exactly once; Result=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF. REMU 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same -> 0. All complete in cycle 34.
- Start DIV, assert start again in cycles 5 and 34 with different operands -> both ignored; first result correct; busy drops in cycle 35.
- Start MUL 3*4, kill in cycle 10 -> busy=0 in cycle 11; done never pulses; Result retains 12 from a prior MUL 3*4, or 0 if none since reset.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider.
// Latency: start sampled at edge 0 -> busy cycles 1..WIDTH+2, done pulse in cycle WIDTH+2.
// Backpressure: busy stalls the pipeline; start while busy is dropped, kill aborts to IDLE.
//
// Ports: clk/reset (sync, active-high), start/kill control, Funct3 selects the op,
// SrcA/SrcB operands, busy/done status, Result registered and held between completions.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [2:0]         op;
    logic               neg_a, neg_b, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    // hi/lo: product high/low halves for multiply; remainder/quotient for divide
    logic [WIDTH-1:0]   hi, lo;
    logic [CNT_W-1:0]   cnt;

    // Operand capture
    logic               in_div, in_sgn_a, in_sgn_b, in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;

    always_comb begin
        in_div   = Funct3[2];
        in_sgn_a = in_div ? ~Funct3[0] : (Funct3 != 3'b011);
        in_sgn_b = in_div ? ~Funct3[0] : ~Funct3[1];
        in_neg_a = in_sgn_a & SrcA[WIDTH-1];
        in_neg_b = in_sgn_b & SrcB[WIDTH-1];
        // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude
        in_mag_a = in_neg_a ? -SrcA : SrcA;
        in_mag_b = in_neg_b ? -SrcB : SrcB;
    end

    // One iteration step
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag};
    end

    // Sign fix-up and output select
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, a_orig, fix_res;

    always_comb begin
        prod_s = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
        quo_s  = (neg_a ^ neg_b) ? -lo : lo;
        rem_s  = neg_a ? -hi : hi;
        a_orig = neg_a ? -a_mag : a_mag;
        fix_res = '0;
        case (op)
            3'b000:                 fix_res = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = b_zero ? {WIDTH{1'b1}} : quo_s;
            default:                fix_res = b_zero ? a_orig : rem_s;
        endcase
    end

    // FSM
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !kill) state_nxt = CALC;
            CALC: begin
                if (kill)                              state_nxt = IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))     state_nxt = FIX;
            end
            FIX:     state_nxt = kill ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            op     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            Result <= '0;
        end else begin
            case (state)
                IDLE: if (start && !kill) begin
                    op     <= Funct3;
                    neg_a  <= in_neg_a;
                    neg_b  <= in_neg_b;
                    b_zero <= (SrcB == '0);
                    a_mag  <= in_mag_a;
                    b_mag  <= in_mag_b;
                    hi     <= '0;
                    // divide shifts the dividend out of lo; multiply shifts the multiplier out
                    lo     <= in_div ? in_mag_a : in_mag_b;
                    cnt    <= '0;
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op[2]) begin
                        if (div_diff[WIDTH]) begin
                            hi <= div_shift[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b0};
                        end else begin
                            hi <= div_diff[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        hi <= mul_sum[WIDTH:1];
                        lo <= {mul_sum[0], lo[WIDTH-1:1]};
                    end
                end
                FIX: if (!kill) Result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule
